ita_job_arbiter: RTL and testbench



---
 rtl/ita_job_arbiter_if.sv | 45 ++++
 rtl/ita_job_arbiter.sv | 175 +++++++++++++++++
 tb/tb_ita_job_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ita_job_arbiter_if.sv
// ita_job_arbiter_if: job-port, ITA-control and completion signals of
// ita_job_arbiter, bundled so a bench or a parent drives them as one port.
//
// Handshake rule for both channels (req_* and done_*): a transfer happens
// in a cycle where valid and ready are both 1 at the rising clock edge.
// The producer may drop valid before it sees ready; nothing is transferred
// in that case. Once the arbiter raises done_valid_o it holds the token
// and its ID stable until done_ready_i is seen.
interface ita_job_arbiter_if #(
  parameter int unsigned NumReq    = 2,
  parameter int unsigned CtrlWidth = 256,
  parameter int unsigned CntWidth  = 16
);
  localparam int unsigned IdW = (NumReq > 1) ? $clog2(NumReq) : 1;

  logic [NumReq-1:0]           req_valid_i;
  logic [NumReq-1:0]           req_ready_o;
  logic [NumReq*CtrlWidth-1:0] req_ctrl_i;
  logic [CtrlWidth-1:0]        ita_ctrl_o;
  logic                        ita_start_o;
  logic                        ita_busy_i;
  logic                        done_valid_o;
  logic                        done_ready_i;
  logic [IdW-1:0]              done_id_o;
  logic [IdW-1:0]              active_id_o;
  logic                        idle_o;
  logic [CntWidth-1:0]         jobs_done_o;
  logic                        error_o;
  // Encoded FSM state, for observation only.
  logic [2:0]                  dbg_state_o;

  // Arbiter side.
  modport slave (
    input  req_valid_i, req_ctrl_i, ita_busy_i, done_ready_i,
    output req_ready_o, ita_ctrl_o, ita_start_o, done_valid_o, done_id_o,
           active_id_o, idle_o, jobs_done_o, error_o, dbg_state_o
  );

  // Requester / ITA side.
  modport master (
    output req_valid_i, req_ctrl_i, ita_busy_i, done_ready_i,
    input  req_ready_o, ita_ctrl_o, ita_start_o, done_valid_o, done_id_o,
           active_id_o, idle_o, jobs_done_o, error_o, dbg_state_o
  );
endinterface

// File: rtl/ita_job_arbiter.sv
// ita_job_arbiter: round-robin front end that lets NumReq requesters share
// one ITA. A granted descriptor is held on ita_ctrl_o for the whole job, a
// one-cycle start pulse launches it, ITA busy is tracked to detect the end,
// and a completion token tagged with the requester ID is returned.
//
// Optional feature (macro ITA_JOB_ARB_TIMEOUT_EN): a watchdog in WaitBusy.
// If busy has not risen after TimeoutCycles cycles, error_o pulses once and
// the job is completed anyway so the requester still gets its token.
// Without the macro error_o is tied low and WaitBusy waits indefinitely.
module ita_job_arbiter #(
  parameter int unsigned NumReq        = 2,
  parameter int unsigned CtrlWidth     = 256,
  parameter int unsigned CntWidth      = 16,
  parameter int unsigned TimeoutCycles = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  ita_job_arbiter_if.slave  bus
);
  localparam int unsigned IdW = (NumReq > 1) ? $clog2(NumReq) : 1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_RUN       = 3'd3,
    ST_DONE      = 3'd4
  } state_e;

  state_e               state_q;
  logic [IdW-1:0]       rr_q;
  logic [IdW-1:0]       active_id_q;
  logic [CtrlWidth-1:0] ctrl_q;
  logic                 start_q;
  logic                 done_valid_q;
  logic                 idle_q;
  logic [CntWidth-1:0]  jobs_q;

  logic                 grant_valid;
  logic [IdW-1:0]       grant_idx;
  logic [IdW-1:0]       rr_d;
  logic [IdW:0]         cand_sum;
  logic [IdW-1:0]       cand;
  logic [NumReq-1:0]    ready;
  logic                 req_hs;
  logic                 done_hs;

`ifdef ITA_JOB_ARB_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TimeoutCycles + 1);
  logic [ToW-1:0] to_cnt_q;
  logic           err_q;
  logic           to_hit;

  assign to_hit = (to_cnt_q == ToW'(TimeoutCycles - 1));
`endif

  // Round-robin pick: first valid requester at or after the pointer, wrapping.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand_sum    = '0;
    cand        = '0;
    for (int k = 0; k < int'(NumReq); k++) begin
      cand_sum = {1'b0, rr_q} + (IdW+1)'(k);
      if (cand_sum >= (IdW+1)'(NumReq)) begin
        cand_sum = cand_sum - (IdW+1)'(NumReq);
      end
      cand = cand_sum[IdW-1:0];
      if (!grant_valid && bus.req_valid_i[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Ready is one-hot on the grant, only in Idle and only while the ITA is free.
  always_comb begin
    ready = '0;
    if (state_q == ST_IDLE && !bus.ita_busy_i && grant_valid) begin
      ready[grant_idx] = 1'b1;
    end
  end

  assign req_hs  = |ready;
  assign done_hs = done_valid_q & bus.done_ready_i;
  assign rr_d    = (grant_idx == IdW'(NumReq - 1)) ? '0 : grant_idx + IdW'(1);

  // Job FSM: Idle -> Launch -> WaitBusy -> Run -> Done -> Idle, registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      rr_q         <= '0;
      active_id_q  <= '0;
      ctrl_q       <= '0;
      start_q      <= 1'b0;
      done_valid_q <= 1'b0;
      idle_q       <= 1'b1;
      jobs_q       <= '0;
`ifdef ITA_JOB_ARB_TIMEOUT_EN
      to_cnt_q     <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      start_q <= 1'b0;
`ifdef ITA_JOB_ARB_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (req_hs) begin
            ctrl_q      <= bus.req_ctrl_i[grant_idx*CtrlWidth +: CtrlWidth];
            active_id_q <= grant_idx;
            rr_q        <= rr_d;
            start_q     <= 1'b1;
            idle_q      <= 1'b0;
            state_q     <= ST_LAUNCH;
          end
        end
        // Busy is deliberately not looked at during the launch cycle.
        ST_LAUNCH: begin
          state_q <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (bus.ita_busy_i) begin
            state_q  <= ST_RUN;
`ifdef ITA_JOB_ARB_TIMEOUT_EN
            to_cnt_q <= '0;
          end else if (to_hit) begin
            to_cnt_q     <= '0;
            err_q        <= 1'b1;
            done_valid_q <= 1'b1;
            state_q      <= ST_DONE;
          end else begin
            to_cnt_q <= to_cnt_q + ToW'(1);
`endif
          end
        end
        ST_RUN: begin
          if (!bus.ita_busy_i) begin
            done_valid_q <= 1'b1;
            state_q      <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (done_hs) begin
            done_valid_q <= 1'b0;
            jobs_q       <= jobs_q + CntWidth'(1);
            idle_q       <= 1'b1;
            state_q      <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready_o  = ready;
  assign bus.ita_ctrl_o   = ctrl_q;
  assign bus.ita_start_o  = start_q;
  assign bus.done_valid_o = done_valid_q;
  assign bus.done_id_o    = active_id_q;
  assign bus.active_id_o  = active_id_q;
  assign bus.idle_o       = idle_q;
  assign bus.jobs_done_o  = jobs_q;
  assign bus.dbg_state_o  = state_q;
`ifdef ITA_JOB_ARB_TIMEOUT_EN
  assign bus.error_o      = err_q;
`else
  // No watchdog in this build; the limit is only referenced to keep it bound.
  assign bus.error_o      = 1'b0 & (TimeoutCycles != 0);
`endif

endmodule

// File: tb/tb_ita_job_arbiter.sv
// tb_ita_job_arbiter: directed bench for ita_job_arbiter with three
// requesters, 32-bit descriptors and a 4-bit job counter (to reach the wrap).
module tb_ita_job_arbiter;
  localparam int unsigned NR = 3;
  localparam int unsigned CW = 32;
  localparam int unsigned NW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int checks   = 0;
  int failures = 0;

  logic [CW-1:0] ctrl_tab [NR];
  logic [1:0]    exp_q [$];
  logic [NW-1:0] exp_jobs = '0;
  int            exp_rr   = 0;

  ita_job_arbiter_if #(.NumReq(NR), .CtrlWidth(CW), .CntWidth(NW)) bus_if ();

  ita_job_arbiter #(
    .NumReq(NR), .CtrlWidth(CW), .CntWidth(NW), .TimeoutCycles(64)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus_if)
  );

  // Clock and run-time guard
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "global timeout");
  end

  typedef struct {
    logic [2:0]  valid;
    logic        busy;
    logic        dready;
    logic [2:0]  e_ready;
    logic        e_start;
    logic        e_dvalid;
    logic [1:0]  e_did;
    logic        e_idle;
    logic [1:0]  e_aid;
    logic [31:0] e_ctrl;
    logic [3:0]  e_jobs;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t mk(input logic [2:0] valid, input logic busy, input logic dready,
                              input logic [2:0] e_ready, input logic e_start, input logic e_dvalid,
                              input logic [1:0] e_did, input logic e_idle, input logic [1:0] e_aid,
                              input logic [31:0] e_ctrl, input logic [3:0] e_jobs);
    vec_t v;
    v.valid = valid;   v.busy = busy;         v.dready = dready;
    v.e_ready = e_ready; v.e_start = e_start; v.e_dvalid = e_dvalid;
    v.e_did = e_did;   v.e_idle = e_idle;     v.e_aid = e_aid;
    v.e_ctrl = e_ctrl; v.e_jobs = e_jobs;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Reference round-robin choice from the bench's own pointer model.
  function automatic int model_grant(input logic [2:0] valid);
    for (int k = 0; k < int'(NR); k++) begin
      int c;
      c = (exp_rr + k) % int'(NR);
      if (valid[c]) return c;
    end
    return -1;
  endfunction

  // Drive valids, wait for the grant, then check Launch and first WaitBusy cycle.
  task automatic start_job(input logic [2:0] valid, input int exp_id);
    int n;
    n = 0;
    bus_if.req_valid_i = valid;
    bus_if.ita_busy_i  = 1'b0;
    #1;
    while (bus_if.req_ready_o == '0 && n < 40) begin
      cyc();
      #1;
      n++;
    end
    check("grant_seen", 32'(bus_if.req_ready_o != '0), 1);
    check("grant_onehot", 32'(bus_if.req_ready_o), 32'd1 << exp_id);
    exp_q.push_back(2'(exp_id));
    exp_rr = (exp_id + 1) % int'(NR);
    cyc();
    check("launch_start", 32'(bus_if.ita_start_o), 1);
    check("launch_ctrl", bus_if.ita_ctrl_o, ctrl_tab[exp_id]);
    check("launch_aid", 32'(bus_if.active_id_o), exp_id);
    check("launch_idle", 32'(bus_if.idle_o), 0);
    check("launch_ready", 32'(bus_if.req_ready_o), 0);
    cyc();
    check("start_one_cycle", 32'(bus_if.ita_start_o), 0);
  endtask

  // From WaitBusy: busy high for busy_len cycles, then the done token,
  // optionally held back by done_ready=0 for hold cycles.
  task automatic finish_job(input int busy_len, input int hold);
    int n;
    logic [1:0] eid;
    bus_if.ita_busy_i = 1'b1;
    repeat (busy_len) cyc();
    bus_if.ita_busy_i   = 1'b0;
    bus_if.done_ready_i = (hold == 0);
    n = 0;
    #1;
    while (!bus_if.done_valid_o && n < 20) begin
      cyc();
      #1;
      n++;
    end
    check("done_seen", 32'(bus_if.done_valid_o), 1);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty: got token expected none queued");
      eid = '0;
    end else begin
      eid = exp_q.pop_front();
    end
    check("done_id", 32'(bus_if.done_id_o), 32'(eid));
    for (int h = 0; h < hold; h++) begin
      check("hold_valid", 32'(bus_if.done_valid_o), 1);
      check("hold_id", 32'(bus_if.done_id_o), 32'(eid));
      check("hold_ready", 32'(bus_if.req_ready_o), 0);
      check("hold_jobs", 32'(bus_if.jobs_done_o), 32'(exp_jobs));
      cyc();
      #1;
    end
    bus_if.done_ready_i = 1'b1;
    cyc();
    exp_jobs = exp_jobs + 1'b1;
    check("after_done_jobs", 32'(bus_if.jobs_done_o), 32'(exp_jobs));
    check("after_done_valid", 32'(bus_if.done_valid_o), 0);
    check("after_done_idle", 32'(bus_if.idle_o), 1);
  endtask

  task automatic do_job(input logic [2:0] valid, input int busy_len, input int hold);
    int id;
    id = model_grant(valid);
    start_job(valid, id);
    finish_job(busy_len, hold);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(bus_if.req_ready_o), 0);
    check({tag, "_start"}, 32'(bus_if.ita_start_o), 0);
    check({tag, "_dvalid"}, 32'(bus_if.done_valid_o), 0);
    check({tag, "_idle"}, 32'(bus_if.idle_o), 1);
    check({tag, "_ctrl"}, bus_if.ita_ctrl_o, 0);
    check({tag, "_aid"}, 32'(bus_if.active_id_o), 0);
    check({tag, "_jobs"}, 32'(bus_if.jobs_done_o), 0);
    check({tag, "_error"}, 32'(bus_if.error_o), 0);
    check({tag, "_state"}, 32'(bus_if.dbg_state_o), 0);
  endtask

  initial begin
    logic [31:0] ca;
    logic [31:0] cb;
    logic        saw_token;
    int          n;

    ctrl_tab[0] = 32'hA5A5_A5A5;
    ctrl_tab[1] = 32'h5A5A_1111;
    ctrl_tab[2] = 32'hC3C3_2222;
    ca = ctrl_tab[0];
    cb = ctrl_tab[1];
    bus_if.req_ctrl_i   = {ctrl_tab[2], ctrl_tab[1], ctrl_tab[0]};
    bus_if.req_valid_i  = '0;
    bus_if.ita_busy_i   = 1'b0;
    bus_if.done_ready_i = 1'b1;

    // Single job on req0, then busy gating with req1 while req0/req2 also ask.
    //             valid   busy dr  ready   st dv did idle aid ctrl jobs
    vecs.push_back(mk(3'b000, 0, 1, 3'b000, 0, 0, 0, 1, 0, 0,  0)); // idle
    vecs.push_back(mk(3'b001, 0, 1, 3'b001, 0, 0, 0, 1, 0, 0,  0)); // T: handshake
    vecs.push_back(mk(3'b000, 0, 1, 3'b000, 1, 0, 0, 0, 0, ca, 0)); // T+1 launch
    vecs.push_back(mk(3'b110, 0, 1, 3'b000, 0, 0, 0, 0, 0, ca, 0)); // T+2 waitbusy
    for (int i = 3; i <= 19; i++)
      vecs.push_back(mk(3'b010, 1, 1, 3'b000, 0, 0, 0, 0, 0, ca, 0)); // busy
    vecs.push_back(mk(3'b000, 0, 1, 3'b000, 0, 0, 0, 0, 0, ca, 0)); // T+20 busy falls
    vecs.push_back(mk(3'b000, 0, 1, 3'b000, 0, 1, 0, 0, 0, ca, 0)); // T+21 done
    vecs.push_back(mk(3'b100, 1, 1, 3'b000, 0, 0, 0, 1, 0, ca, 1)); // idle, busy
    vecs.push_back(mk(3'b000, 1, 1, 3'b000, 0, 0, 0, 1, 0, ca, 1)); // req2 dropped
    vecs.push_back(mk(3'b011, 1, 1, 3'b000, 0, 0, 0, 1, 0, ca, 1)); // gated
    vecs.push_back(mk(3'b011, 1, 1, 3'b000, 0, 0, 0, 1, 0, ca, 1)); // gated
    vecs.push_back(mk(3'b011, 0, 1, 3'b010, 0, 0, 0, 1, 0, ca, 1)); // req1 wins
    vecs.push_back(mk(3'b000, 0, 1, 3'b000, 1, 0, 0, 0, 1, cb, 1)); // launch req1
    vecs.push_back(mk(3'b000, 0, 1, 3'b000, 0, 0, 0, 0, 1, cb, 1)); // waitbusy

    // Reset block
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    cyc();

    // Vector table
    for (int i = 0; i < vecs.size(); i++) begin
      bus_if.req_valid_i  = vecs[i].valid;
      bus_if.ita_busy_i   = vecs[i].busy;
      bus_if.done_ready_i = vecs[i].dready;
      #1;
      check($sformatf("v%0d_ready", i), 32'(bus_if.req_ready_o), 32'(vecs[i].e_ready));
      check($sformatf("v%0d_start", i), 32'(bus_if.ita_start_o), 32'(vecs[i].e_start));
      check($sformatf("v%0d_dvalid", i), 32'(bus_if.done_valid_o), 32'(vecs[i].e_dvalid));
      if (vecs[i].e_dvalid)
        check($sformatf("v%0d_did", i), 32'(bus_if.done_id_o), 32'(vecs[i].e_did));
      check($sformatf("v%0d_idle", i), 32'(bus_if.idle_o), 32'(vecs[i].e_idle));
      check($sformatf("v%0d_aid", i), 32'(bus_if.active_id_o), 32'(vecs[i].e_aid));
      check($sformatf("v%0d_ctrl", i), bus_if.ita_ctrl_o, vecs[i].e_ctrl);
      check($sformatf("v%0d_jobs", i), 32'(bus_if.jobs_done_o), 32'(vecs[i].e_jobs));
      cyc();
    end

    // The req1 job from the table is still in WaitBusy.
    exp_jobs = 4'd1;
    exp_rr   = 2;
    exp_q.push_back(2'd1);
    bus_if.req_valid_i = '0;
    finish_job(2, 0);

    // Round robin with req0 and req1 always valid: 0,1,0,1.
    for (int j = 0; j < 4; j++) begin
      check("rr_order", model_grant(3'b011), (j % 2));
      do_job(3'b011, 3, 0);
    end

    // Done backpressure for 10 cycles on a req2 job.
    do_job(3'b100, 3, 10);

    // Fill up to 17 completed jobs: the 4-bit counter wraps to 1.
    for (int j = 0; j < 10; j++) do_job(3'b111, 1, 0);
    check("counter_wrap", 32'(bus_if.jobs_done_o), 1);

`ifdef ITA_JOB_ARB_TIMEOUT_EN
    // Busy never rises: error pulse after 64 WaitBusy cycles, then a token.
    begin
      int id;
      logic [1:0] eid;
      id = model_grant(3'b001);
      start_job(3'b001, id);
      bus_if.req_valid_i  = '0;
      bus_if.done_ready_i = 1'b1;
      n = 0;
      #1;
      while (!bus_if.error_o && n < 200) begin
        cyc();
        #1;
        n++;
      end
      check("timeout_error", 32'(bus_if.error_o), 1);
      check("timeout_cycles", n, 64);
      check("timeout_token", 32'(bus_if.done_valid_o), 1);
      eid = exp_q.pop_front();
      check("timeout_id", 32'(bus_if.done_id_o), 32'(eid));
      cyc();
      exp_jobs = exp_jobs + 1'b1;
      check("timeout_pulse_end", 32'(bus_if.error_o), 0);
      check("timeout_jobs", 32'(bus_if.jobs_done_o), 32'(exp_jobs));
    end
`else
    // Busy never rises: WaitBusy waits with no token and no error.
    begin
      int id;
      logic seen_err;
      id = model_grant(3'b001);
      start_job(3'b001, id);
      bus_if.req_valid_i = '0;
      saw_token = 1'b0;
      seen_err  = 1'b0;
      for (int c = 0; c < 80; c++) begin
        #1;
        if (bus_if.done_valid_o) saw_token = 1'b1;
        if (bus_if.error_o) seen_err = 1'b1;
        cyc();
      end
      check("nowd_token", 32'(saw_token), 0);
      check("nowd_error", 32'(seen_err), 0);
      check("nowd_state", 32'(bus_if.dbg_state_o), 2);
      finish_job(2, 0);
    end
`endif

    // Reset while in Run: everything back to reset values at once.
    begin
      int id;
      id = model_grant(3'b010);
      start_job(3'b010, id);
      bus_if.ita_busy_i = 1'b1;
      repeat (3) cyc();
      check("pre_reset_state", 32'(bus_if.dbg_state_o), 3);
      bus_if.req_valid_i = '0;
      bus_if.ita_busy_i  = 1'b0;
      #3;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrun_reset");
      exp_q.delete();
      exp_jobs = '0;
      exp_rr   = 0;
      repeat (2) cyc();
      rst_n = 1'b1;
      saw_token = 1'b0;
      for (int c = 0; c < 20; c++) begin
        cyc();
        #1;
        if (bus_if.done_valid_o) saw_token = 1'b1;
      end
      check("no_token_after_reset", 32'(saw_token), 0);
      check("rr_reset_pick", model_grant(3'b011), 0);
      do_job(3'b011, 2, 0);
      check("jobs_after_reset", 32'(bus_if.jobs_done_o), 1);
    end

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
